// File: rtl/systola_pkg.sv
// Shared types and default geometry for the systolic-array result path.
package systola_pkg;

    localparam int DEF_COLS     = 8;
    localparam int DEF_ROWS     = 8;
    localparam int DEF_OUTWIDTH = 32;
    localparam int COL_W        = $clog2(DEF_COLS);
    localparam int ROW_W        = $clog2(DEF_ROWS);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH
    } drain_state_t;

endpackage

// File: rtl/drain_out_reg.sv
// Valid/ready output register holding one result word plus its column/row tags.
module drain_out_reg
    import systola_pkg::*;
#(
    parameter int OUTWIDTH = DEF_OUTWIDTH,
    parameter int CW       = COL_W,
    parameter int RW       = ROW_W
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                load_i,
    input  logic [OUTWIDTH-1:0] data_i,
    input  logic [CW-1:0]       col_i,
    input  logic [RW-1:0]       row_i,
    input  logic                m_ready_i,
    output logic                ready_o,
    output logic                m_valid_o,
    output logic [OUTWIDTH-1:0] m_data_o,
    output logic [CW-1:0]       m_col_o,
    output logic [RW-1:0]       m_row_o
);

    logic                valid_q, valid_d;
    logic [OUTWIDTH-1:0] data_q,  data_d;
    logic [CW-1:0]       col_q,   col_d;
    logic [RW-1:0]       row_q,   row_d;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        col_d   = col_q;
        row_d   = row_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            col_d   = col_i;
            row_d   = row_i;
        end else if (m_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            // NOTE: the payload is reset too, so m_data reads 0 after reset instead of a stale word.
            data_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    assign ready_o   = !valid_q || m_ready_i;
    assign m_valid_o = valid_q;
    assign m_data_o  = data_q;
    assign m_col_o   = col_q;
    assign m_row_o   = row_q;

endmodule

// File: rtl/col_drain_sched.sv
// Drains COLS column controllers, ROWS words each, into one tagged valid/ready stream.
// Define COL_DRAIN_TIMEOUT_EN to add the per-word stall timeout (sticky err, column skip).
module col_drain_sched
    import systola_pkg::*;
#(
    parameter int COLS     = DEF_COLS,
    parameter int ROWS     = DEF_ROWS,
    parameter int OUTWIDTH = DEF_OUTWIDTH
`ifdef COL_DRAIN_TIMEOUT_EN
    ,
    parameter int TIMEOUT  = 64
`endif
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start_i,
    input  logic [COLS-1:0]                col_rvalid_i,
    input  logic [COLS-1:0][OUTWIDTH-1:0]  col_data_i,
    output logic [COLS-1:0]                col_read_o,
    output logic                           m_valid_o,
    input  logic                           m_ready_i,
    output logic [OUTWIDTH-1:0]            m_data_o,
    output logic [$clog2(COLS)-1:0]        m_col_o,
    output logic [$clog2(ROWS)-1:0]        m_row_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o
);

    localparam int            CW       = $clog2(COLS);
    localparam int            RW       = $clog2(ROWS);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    drain_state_t  state_q, state_d;
    logic [CW-1:0] col_idx_q, col_idx_d;
    logic [RW-1:0] row_idx_q, row_idx_d;
    logic          done_q, done_d;
    logic          out_ready;
    logic          cur_rvalid;
    logic          load;
    logic          last_word;
    logic          timeout;

    assign cur_rvalid = col_rvalid_i[col_idx_q];
    // Gated by rstn so no pop strobe escapes while a synchronous reset is pending.
    assign load       = rstn && (state_q == DRAIN) && cur_rvalid && out_ready;
    assign last_word  = (col_idx_q == LAST_COL) && (row_idx_q == LAST_ROW);
    assign col_read_o = load ? (COLS'(1) << col_idx_q) : '0;

`ifdef COL_DRAIN_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);

    logic [SW-1:0] stall_q, stall_d;
    logic          err_q, err_d;
    logic          stalled;

    assign stalled = (state_q == DRAIN) && !cur_rvalid;
    assign timeout = stalled && (stall_q == SW'(TIMEOUT - 1));

    always_comb begin
        stall_d = stall_q;
        err_d   = err_q;
        if (load || timeout) begin
            stall_d = '0;
        end else if (stalled) begin
            stall_d = stall_q + 1'b1;
        end
        if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = DRAIN;
                    col_idx_d = '0;
                    row_idx_d = '0;
                end
            end
            DRAIN: begin
                if (load) begin
                    row_idx_d = row_idx_q + 1'b1;
                    if (row_idx_q == LAST_ROW) begin
                        col_idx_d = col_idx_q + 1'b1;
                    end
                    if (last_word) begin
                        state_d = FLUSH;
                    end
                end else if (timeout) begin
                    row_idx_d = '0;
                    col_idx_d = col_idx_q + 1'b1;
                    // Skipping the last column: finish now unless a word is still held back.
                    if (col_idx_q == LAST_COL) begin
                        if (out_ready) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (m_valid_o && m_ready_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            col_idx_q <= '0;
            row_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            row_idx_q <= row_idx_d;
            done_q    <= done_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;

    drain_out_reg #(
        .OUTWIDTH (OUTWIDTH),
        .CW       (CW),
        .RW       (RW)
    ) u_out_reg (
        .clk       (clk),
        .rstn      (rstn),
        .load_i    (load),
        .data_i    (col_data_i[col_idx_q]),
        .col_i     (col_idx_q),
        .row_i     (row_idx_q),
        .m_ready_i (m_ready_i),
        .ready_o   (out_ready),
        .m_valid_o (m_valid_o),
        .m_data_o  (m_data_o),
        .m_col_o   (m_col_o),
        .m_row_o   (m_row_o)
    );

endmodule

// File: doc/col_drain_sched.md
Name: col_drain_sched

Overview:
- Drains the per-column output controllers of the systolic array into one result stream after a tile completes.
- Visits columns 0..COLS-1 in order and pops exactly ROWS words from each.
- Each popped word is tagged with its column and row index and sent downstream over a valid/ready handshake.
- Sits between the column output controllers and the result writeback/DMA interface.

Parameters:
- COLS, 8, number of array columns (power of two, >=2).
- ROWS, 8, words drained per column (power of two, >=2).
- OUTWIDTH, 32, result word width.
- TIMEOUT, 64, stall-cycle limit per word; used only with COL_DRAIN_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- start  in  1  single-cycle pulse that begins draining one tile.
- col_rvalid  in  COLS  per-column "word available" flag.
- col_data  in  COLS x OUTWIDTH  per-column head word.
- col_read  out  COLS  one-hot pop strobe to the column controllers.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  OUTWIDTH  output word.
- m_col  out  $clog2(COLS)  column tag of m_data.
- m_row  out  $clog2(ROWS)  row tag of m_data.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  single-cycle pulse; tile fully delivered.
- err  out  1  sticky timeout flag; constant 0 when the feature is out.

Behaviour:
- Reset values: FSM IDLE; col_read=0, m_valid=0, m_data=0, m_col=0, m_row=0, busy=0, done=0, err=0.
- Reset mid-drain discards the output register and all counters. No col_read is issued during reset.
- FSM states:
  - IDLE: start moves to DRAIN, clearing col_idx=0 and row_idx=0.
  - DRAIN: moves to FLUSH when the last word (col_idx=COLS-1, row_idx=ROWS-1) is loaded into the output register.
  - FLUSH: waits for m_valid && m_ready, then goes to IDLE with done=1 for that single cycle.
- start is ignored outside IDLE.
- Load condition: state==DRAIN && col_rvalid[col_idx] && (!m_valid || m_ready).
- On load:
  - col_read[col_idx]=1 combinationally in the same cycle; all other col_read bits are 0.
  - m_data<=col_data[col_idx], m_col<=col_idx, m_row<=row_idx, m_valid<=1.
- Counter update on load: row_idx increments. When row_idx==ROWS-1 it wraps to 0 and col_idx increments.
- Latency: one cycle from the load cycle to m_valid.
- Throughput: one word per cycle while m_ready=1 and data is available.
- Handshake hold: m_valid with !m_ready freezes m_data/m_col/m_row, and no load occurs.
- Simultaneous accept and load in the same cycle: m_valid stays 1 and the new word replaces the old.
- Accept with no load: m_valid<=0.
- col_rvalid of non-current columns is ignored, and col_read is never asserted for them.
- An empty current column stalls DRAIN indefinitely, unless the optional feature is compiled in.
- busy=(state!=IDLE).

Optional Feature:
- COL_DRAIN_TIMEOUT_EN defined:
  - A stall counter counts DRAIN cycles in which col_rvalid[col_idx]=0. It clears on every load.
  - When the counter reaches TIMEOUT, err is set (sticky until reset) and the remaining words of the current column are skipped: row_idx=0 and col_idx increments.
  - If the skipped column is the last column, the FSM goes to FLUSH, or straight to IDLE with done=1 when m_valid=0.
- COL_DRAIN_TIMEOUT_EN undefined: no stall counter, err tied to 0, and stalls are unbounded.

Decomposition:
- Package systola_pkg holds:
  - drain_state_t enum {IDLE, DRAIN, FLUSH};
  - localparam widths COL_W=$clog2(COLS) and ROW_W=$clog2(ROWS);
  - the default OUTWIDTH.
- One natural sub-module, drain_out_reg: the valid/ready output register carrying data plus tags. It takes a load enable and outputs m_valid/m_data/m_col/m_row.
- The FSM, counters and column mux stay in col_drain_sched.

Test Plan:
- Full drain: COLS=ROWS=8, all col_rvalid=1, m_ready=1, start pulse, col_data[c]=c*16+row.
  - Expect 64 words on consecutive cycles in order (col,row)=(0,0)..(7,7).
  - Expect done exactly one cycle after the final accept; busy high throughout.
- Backpressure: m_ready=0 for 5 cycles mid-column 3.
  - Expect m_data, m_col and m_row frozen, and no col_read pulses during the stall.
  - Expect the sequence to resume with no loss or duplication.
- Sparse data: col_rvalid[2] low for 10 cycles.
  - Expect DRAIN to hold at col_idx=2 with no col_read, then continue.
  - Expect err=0 with the feature out.
- start while busy is ignored, with no restart. Assert rstn=0 at word 20.
  - Expect all outputs at reset values the next cycle.
  - Expect a fresh start afterwards to drain from (0,0).
- With COL_DRAIN_TIMEOUT_EN and TIMEOUT=64: col_rvalid[5]=0 permanently.
  - Expect err set after 64 stall cycles and column 5's remaining words skipped.
  - Expect columns 6-7 still drained and done asserted.
